fetch_stage: RTL
================

Name: fetch_stage

Overview:
Instruction-fetch front end that feeds the decode stage of the 5-stage RV32I pipeline core.
- Owns the PC and drives a request/response instruction-memory port.
- Buffers returned words in a small FIFO and presents one instruction per cycle on the IF/ID register.
- Honours decode stalls and execute-stage redirects (taken branches, jumps), including discarding stale in-flight fetches.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
BUF_DEPTH, 2, fetch-buffer entries (power of 2, >=2)
NOP_INSTR, 32'h0000_0013, encoding driven on if_id_instr when no valid instruction (addi x0,x0,0)

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset asserted)
imem_req  out  1  fetch request valid
imem_addr  out  32  word-aligned fetch address (bits[1:0]=0)
imem_gnt  in  1  request accepted this cycle (handshake: imem_req & imem_gnt)
imem_rvalid  in  1  read data valid; exactly one per granted request, >=1 cycle after grant, in order
imem_rdata  in  32  instruction word
id_stall  in  1  decode cannot accept; hold IF/ID register
ex_redirect  in  1  redirect fetch (taken branch/jump resolved in EX)
ex_redirect_pc  in  32  redirect target
if_id_valid  out  1  IF/ID holds a real instruction
if_id_pc  out  32  PC of if_id_instr
if_id_pc4  out  32  if_id_pc + 4
if_id_instr  out  32  instruction word, or NOP_INSTR when invalid
misalign_err  out  1  sticky: a redirect target had bits[1:0]!=0

Behaviour:
- Reset (rst=0, async): pc=RESET_PC, imem_req=0, FIFO empty, outstanding=0, drop=0.
  - if_id_valid=0, if_id_pc=0, if_id_pc4=0, if_id_instr=NOP_INSTR, misalign_err=0.
- First imem_req=1 in the first cycle after rst rises, with imem_addr=RESET_PC.
- Request rule:
  - imem_req=1 when outstanding==0 and FIFO free entries >=1, counting the response slot.
  - At most one outstanding request.
  - imem_addr=pc, held stable while imem_req=1 and !imem_gnt.
  - On grant: pc<=pc+4 (mod 2^32), outstanding<=1.
- Response: on imem_rvalid, outstanding<=0.
  - drop=0: push {pc_of_request, rdata} into FIFO.
  - drop=1: discard the word and clear drop.
  - Each request's PC is latched at grant.
- IF/ID load: when !id_stall or !if_id_valid:
  - FIFO non-empty: pop the head into IF/ID, if_id_valid=1.
  - FIFO empty: if_id_valid<=0, if_id_instr<=NOP_INSTR, pc fields hold.
- id_stall with if_id_valid=1: all IF/ID outputs hold; FIFO still fills.
- Redirect (priority over id_stall and all else), same edge:
  - pc<=ex_redirect_pc with bits[1:0] cleared.
  - FIFO flushed; if_id_valid<=0, if_id_instr<=NOP_INSTR.
  - imem_req is suppressed in the redirect cycle; the grant of an already-presented request that cycle is still honoured and treated as in-flight.
  - Any in-flight request (outstanding=1 after this edge) sets drop=1.
  - If imem_rvalid arrives in the redirect cycle, it is discarded.
  - First new request in the next cycle. Redirect-to-IF/ID-valid latency with a 1-cycle memory is 3 cycles.
- misalign_err: set on a redirect with ex_redirect_pc[1:0]!=0; cleared only by reset.
- Simultaneous push and pop are legal at any occupancy. The FIFO never overflows by construction; an overflow is an assertion failure.
- Back-to-back redirects: each one re-flushes; only the last target is fetched.
- Steady state: 1-cycle grant and 1-cycle rvalid give one instruction every 2 cycles (single outstanding).

Test Plan:
1. Reset release, memory always grants, rvalid 1 cycle later, mem[i]=0x100+i -> if_id_pc 0,4,8 with instr 0x100,0x101,0x102; if_id_pc4=pc+4; NOP_INSTR while invalid.
2. id_stall high 6 cycles after the first valid instruction -> IF/ID holds pc=4; FIFO fills to BUF_DEPTH and imem_req drops; on release, pcs 8 and 12 issue on consecutive cycles.
3. imem_gnt low 3 cycles -> imem_addr stable at 0x8 with imem_req high; no pc increment until grant.
4. ex_redirect to 0x40 while the fetch of 0x10 is in flight -> word for 0x10 discarded; next valid if_id_pc=0x40; no instruction from 0x0C/0x10 reaches IF/ID.
5. ex_redirect and id_stall asserted together -> redirect wins: if_id_valid=0 next cycle, pc=target.
6. ex_redirect_pc=0x43 -> misalign_err=1 and stays set; fetch proceeds from 0x40. Assert rst=0 mid-stream -> all outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, issues single-outstanding imem fetches, buffers words and feeds IF/ID.
// Latency: redirect edge to valid IF/ID is 3 cycles with a 1-cycle grant/rvalid memory.
// Backpressure: id_stall holds IF/ID while the buffer fills; imem_req drops when no slot is free.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        id_stall,
  input  logic        ex_redirect,
  input  logic [31:0] ex_redirect_pc,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic [31:0] if_id_instr,
  output logic        misalign_err
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_DEPTH);

  // Fetch control state
  logic [31:0]      r_pc;
  logic             r_req;
  logic             r_outstanding;
  logic             r_drop;
  logic [31:0]      r_req_pc;
  logic             r_misalign;

  // Fetch buffer
  logic [31:0]      r_fifo_pc    [BUF_DEPTH];
  logic [31:0]      r_fifo_instr [BUF_DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;

  // IF/ID register
  logic             r_if_valid;
  logic [31:0]      r_if_pc;
  logic [31:0]      r_if_pc4;
  logic [31:0]      r_if_instr;

  logic             w_grant;
  logic             w_resp;
  logic             w_push;
  logic             w_load;
  logic             w_pop;
  logic             w_outstanding_nxt;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_req_nxt;

  // Handshakes and next-state terms shared by the sequential blocks
  always_comb begin
    w_grant           = r_req & imem_gnt;
    w_resp            = imem_rvalid & r_outstanding;
    // Words for a request issued before a redirect, or arriving in the redirect cycle, are stale.
    w_push            = w_resp & ~r_drop & ~ex_redirect;
    w_load            = ~id_stall | ~r_if_valid;
    w_pop             = ~ex_redirect & w_load & (r_count != '0);
    w_outstanding_nxt = (r_outstanding & ~imem_rvalid) | w_grant;
    if (ex_redirect) begin
      w_count_nxt = '0;
    end else begin
      w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
    // The response slot of an outstanding request is already reserved, so only ask when idle.
    w_req_nxt         = ~w_outstanding_nxt & (w_count_nxt < FULL_CNT);
  end

  // PC, request, in-flight tracking and sticky misalignment flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc          <= RESET_PC;
      r_req         <= 1'b0;
      r_outstanding <= 1'b0;
      r_drop        <= 1'b0;
      r_req_pc      <= 32'h0;
      r_misalign    <= 1'b0;
    end else begin
      r_req         <= w_req_nxt;
      r_outstanding <= w_outstanding_nxt;
      if (w_grant) begin
        r_req_pc <= r_pc;
      end
      if (ex_redirect) begin
        r_pc <= {ex_redirect_pc[31:2], 2'b00};
      end else if (w_grant) begin
        r_pc <= r_pc + 32'd4;
      end
      // Anything still in flight after a redirect belongs to the old path.
      if (ex_redirect) begin
        r_drop <= w_outstanding_nxt;
      end else if (w_resp) begin
        r_drop <= 1'b0;
      end
      if (ex_redirect && (ex_redirect_pc[1:0] != 2'b00)) begin
        r_misalign <= 1'b1;
      end
    end
  end

  // Fetch buffer pointers and occupancy; a redirect empties it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_count <= w_count_nxt;
      if (ex_redirect) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_push) begin
          r_wptr <= r_wptr + PTR_W'(1);
        end
        if (w_pop) begin
          r_rptr <= r_rptr + PTR_W'(1);
        end
      end
    end
  end

  // Fetch buffer storage: each word is tagged with the PC latched at its grant
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_pc[r_wptr]    <= r_req_pc;
      r_fifo_instr[r_wptr] <= imem_rdata;
    end
  end

  // IF/ID register: redirect flushes, otherwise load from the buffer unless decode is stalled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_if_valid <= 1'b0;
      r_if_pc    <= 32'h0;
      r_if_pc4   <= 32'h0;
      r_if_instr <= NOP_INSTR;
    end else if (ex_redirect) begin
      r_if_valid <= 1'b0;
      r_if_instr <= NOP_INSTR;
    end else if (w_load) begin
      if (w_pop) begin
        r_if_valid <= 1'b1;
        r_if_pc    <= r_fifo_pc[r_rptr];
        r_if_pc4   <= r_fifo_pc[r_rptr] + 32'd4;
        r_if_instr <= r_fifo_instr[r_rptr];
      end else begin
        r_if_valid <= 1'b0;
        r_if_instr <= NOP_INSTR;
      end
    end
  end

  // Request gating guarantees a free slot for every accepted word
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(w_push && !w_pop && (r_count == FULL_CNT)));

  assign imem_req     = r_req;
  assign imem_addr    = r_pc;
  assign if_id_valid  = r_if_valid;
  assign if_id_pc     = r_if_pc;
  assign if_id_pc4    = r_if_pc4;
  assign if_id_instr  = r_if_instr;
  assign misalign_err = r_misalign;

endmodule
